// File: rtl/spike_output_collector_pkg.sv
// spike_output_collector_pkg: shared event record and drop counter constants
package spike_output_collector_pkg;

    localparam int DROP_W    = 8;
    localparam int DROP_MAX  = (1 << DROP_W) - 1;
    localparam int MAX_COL_W = 8;
    localparam int MAX_TS_W  = 32;

    // Sized for the widest supported configuration; narrower instances zero-extend.
    typedef struct packed {
        logic [MAX_COL_W-1:0] col;
        logic [MAX_TS_W-1:0]  ts;
    } spike_event_t;

endpackage

// File: rtl/spike_event_fifo.sv
// spike_event_fifo: first-word-fall-through event buffer with full/empty flags
module spike_event_fifo
    import spike_output_collector_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = spike_event_t
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    T mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Storage write; contents need no reset since empty gates the head.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Pointer update; a push is refused at full even when a pop happens.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

endmodule

// File: rtl/spike_output_collector.sv
// spike_output_collector: timestamps column spikes and queues them as events
module spike_output_collector
    import spike_output_collector_pkg::*;
#(
    parameter int NUM_COLS   = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_WIDTH   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [NUM_COLS-1:0]         spike_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(NUM_COLS)-1:0] out_col,
    output logic [TS_WIDTH-1:0]         out_time,
    output logic [DROP_W-1:0]           drop_count
);

    localparam int CW = $clog2(NUM_COLS);

    logic [TS_WIDTH-1:0] ts;
    logic [TS_WIDTH-1:0] stamp [NUM_COLS];
    logic [NUM_COLS-1:0] pending;
    logic [NUM_COLS-1:0] sp;
    logic [NUM_COLS-1:0] gnt_mask;
    logic [NUM_COLS-1:0] drops;
    logic [CW-1:0]       rr_ptr;
    logic [CW-1:0]       grant;
    logic                grant_valid;
    logic                full;
    logic                empty;
    int                  best;
    int                  off;
    int                  drop_sum;
    spike_event_t        din;
    spike_event_t        dout;
    logic                unused_head;

    assign sp          = enable ? spike_in : '0;
    assign gnt_mask    = grant_valid ? (NUM_COLS'(1) << grant) : '0;
    assign drops       = sp & pending & ~gnt_mask;
    assign drop_sum    = int'(drop_count) + $countones(drops);
    assign out_valid   = !empty;
    assign out_col     = out_valid ? CW'(dout.col) : '0;
    assign out_time    = out_valid ? TS_WIDTH'(dout.ts) : '0;
    assign unused_head = ^dout;

    // Round-robin pick: the pending column closest at or after rr_ptr wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        best        = NUM_COLS;
        off         = 0;
        for (int c = 0; c < NUM_COLS; c++) begin
            off = (c >= int'(rr_ptr)) ? c - int'(rr_ptr) : c + NUM_COLS - int'(rr_ptr);
            if (!full && pending[c] && off < best) begin
                best        = off;
                grant       = CW'(c);
                grant_valid = 1'b1;
            end
        end
    end

    // Event record for the granted column, zero-extended into the shared type.
    always_comb begin
        din     = '0;
        din.col = MAX_COL_W'(grant);
        din.ts  = MAX_TS_W'(stamp[grant]);
    end

    // Timestamp, pending/stamp capture, arbiter pointer and drop accounting.
    always_ff @(posedge clk) begin
        if (reset) begin
            ts         <= '0;
            pending    <= '0;
            stamp      <= '{default: '0};
            rr_ptr     <= '0;
            drop_count <= '0;
        end else begin
            if (enable) ts <= ts + TS_WIDTH'(1);
            pending <= (pending & ~gnt_mask) | sp;
            for (int c = 0; c < NUM_COLS; c++)
                if (sp[c] && (!pending[c] || gnt_mask[c])) stamp[c] <= ts;
            if (grant_valid) rr_ptr <= (int'(grant) == NUM_COLS - 1) ? '0 : grant + CW'(1);
            drop_count <= (drop_sum > DROP_MAX) ? DROP_W'(DROP_MAX) : DROP_W'(drop_sum);
        end
    end

    spike_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (spike_event_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (grant_valid),
        .pop   (out_ready),
        .din   (din),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_spike_output_collector.sv
// tb_spike_output_collector: directed checks against a queue-based event model
module tb_spike_output_collector;

    localparam int DEPTH = 8;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [1:0] spike_in;
    logic       out_ready;
    logic       out_valid;
    logic [0:0] out_col;
    logic [15:0] out_time;
    logic [7:0] drop_count;
    logic       w_valid;
    logic [0:0] w_col;
    logic [3:0] w_time;
    logic [7:0] w_drop;

    int tests = 0;
    int fails = 0;
    bit armed = 0;

    spike_output_collector #(.NUM_COLS(2), .FIFO_DEPTH(DEPTH), .TS_WIDTH(16)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .spike_in(spike_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col),
        .out_time(out_time), .drop_count(drop_count)
    );

    spike_output_collector #(.NUM_COLS(2), .FIFO_DEPTH(DEPTH), .TS_WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .enable(enable), .spike_in(spike_in),
        .out_valid(w_valid), .out_ready(out_ready), .out_col(w_col),
        .out_time(w_time), .drop_count(w_drop)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: queue of events, per-column pending/stamp, timestamp, drops.
    typedef struct { int col; int t; } ev_t;
    ev_t q[$];
    int  m_ts, m_rr, m_drop, g;
    bit  m_pend [2];
    int  m_stamp [2];
    bit  s;

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_ts = 0; m_rr = 0; m_drop = 0;
            m_pend = '{0, 0}; m_stamp = '{0, 0};
        end else begin
            g = -1;
            if (q.size() < DEPTH)
                for (int i = 0; i < 2; i++)
                    if (g < 0 && m_pend[(m_rr + i) % 2]) g = (m_rr + i) % 2;
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (g >= 0) begin
                q.push_back('{g, m_stamp[g]});
                m_rr = (g + 1) % 2;
            end
            for (int c = 0; c < 2; c++) begin
                s = enable && spike_in[c];
                if (c == g) begin
                    m_pend[c] = s;
                    if (s) m_stamp[c] = m_ts;
                end else if (s && m_pend[c]) begin
                    m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                end else if (s) begin
                    m_pend[c] = 1;
                    m_stamp[c] = m_ts;
                end
            end
            if (enable) m_ts = (m_ts + 1) % 65536;
        end
    end

    // Per-cycle comparison of the main instance against the model.
    always @(negedge clk) begin
        if (armed) begin
            check("out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) begin
                check("out_col", out_col, q[0].col);
                check("out_time", out_time, q[0].t);
            end
            check("drop_count", drop_count, m_drop);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ts(input int n);
        int k = 0;
        while (m_ts != n && k < 200) begin
            tick();
            k++;
        end
        check("wait_ts", m_ts, n);
    endtask

    task automatic do_reset();
        reset = 1;
        spike_in = 0;
        tick();
        reset = 0;
    endtask

    initial begin
        int n;
        reset = 1; enable = 0; spike_in = 0; out_ready = 0;
        tick();
        armed = 1;
        tick();
        check("reset_valid", out_valid, 0);
        check("reset_col", out_col, 0);
        check("reset_time", out_time, 0);
        check("reset_drop", drop_count, 0);
        reset = 0;

        // single spike at ts=5
        enable = 1; out_ready = 1;
        wait_ts(5);
        spike_in = 2'b01; tick(); spike_in = 0;
        check("single_latency", out_valid, 0);
        tick();
        check("single_valid", out_valid, 1);
        check("single_col", out_col, 0);
        check("single_time", out_time, 5);
        tick();

        // simultaneous spikes; a lone col0 spike at ts=15 moves rr_ptr to 1
        do_reset();
        wait_ts(10);
        spike_in = 2'b11; tick(); spike_in = 0;
        tick();
        check("sim_a_col", out_col, 0);
        check("sim_a_time", out_time, 10);
        tick();
        check("sim_b_col", out_col, 1);
        check("sim_b_time", out_time, 10);
        wait_ts(15);
        spike_in = 2'b01; tick(); spike_in = 0;
        wait_ts(20);
        spike_in = 2'b11; tick(); spike_in = 0;
        tick();
        check("sim_c_col", out_col, 1);
        check("sim_c_time", out_time, 20);
        tick();
        check("sim_d_col", out_col, 0);
        check("sim_d_time", out_time, 20);
        tick(); tick();

        // backpressure: fill, one pending, one drop, then drain 9
        out_ready = 0;
        for (int i = 0; i < 8; i++) begin
            spike_in = (i % 2 == 1) ? 2'b10 : 2'b01;
            tick();
            spike_in = 0;
            tick();
        end
        check("bp_full_valid", out_valid, 1);
        check("bp_head_col", out_col, 0);
        spike_in = 2'b01; tick();
        check("bp_pending_nodrop", drop_count, 0);
        tick(); spike_in = 0;
        check("bp_drop", drop_count, 1);
        out_ready = 1;
        n = 0;
        while (out_valid === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        check("bp_drain_count", n, 9);

        // timestamp wrap on the 4-bit instance
        do_reset();
        out_ready = 1;
        wait_ts(15);
        spike_in = 2'b01; tick(); tick(); spike_in = 0;
        check("wrap_valid", w_valid, 1);
        check("wrap_col", w_col, 0);
        check("wrap_time_a", w_time, 15);
        tick();
        check("wrap_time_b", w_time, 0);
        check("wrap_drop", w_drop, 0);
        tick();

        // drop counter saturation
        out_ready = 0;
        spike_in = 2'b01;
        repeat (320) tick();
        check("sat_255", drop_count, 255);
        repeat (5) tick();
        check("sat_hold", drop_count, 255);
        spike_in = 0; out_ready = 1;
        repeat (15) tick();

        // mid-operation reset with 3 events buffered
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            spike_in = 2'b10; tick(); spike_in = 0; tick();
        end
        check("mid_buffered", out_valid, 1);
        reset = 1; spike_in = 2'b11; out_ready = 1;
        tick();
        reset = 0; spike_in = 2'b01;
        check("mid_valid", out_valid, 0);
        check("mid_drop", drop_count, 0);
        tick(); spike_in = 0;
        check("mid_no_stale", out_valid, 0);
        tick();
        check("mid_new_valid", out_valid, 1);
        check("mid_new_col", out_col, 0);
        check("mid_new_time", out_time, 0);
        tick(); tick();

        armed = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
